pc_fetch_ctrl: RTL and testbench

//  Consumer end of the branch-target path: owns the architectural PC and

---
 rtl/pc_fetch_ctrl.sv | 98 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC, sequences single-outstanding
// instruction fetches over a req/ack handshake and hands each fetched word,
// tagged with its PC, to decode over a valid/ready handshake. Redirects from
// the target adder / branch unit override everything except HALT. A
// misaligned redirect parks the block in HALT until reset.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] DELIVER = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;

  // Instruction addresses must be word aligned; anything else is fatal.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // Request and address come straight from state/pc so the address is
  // guaranteed stable for as long as the request is held.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  // Link value; 32-bit modulo wrap is intended (0xFFFF_FFFC -> 0).
  assign pc_plus4  = pc + 32'd4;

  // Fetch sequencer: redirect has priority, then the per-state handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      inst_valid   <= 1'b0;
      inst_data    <= 32'd0;
      inst_pc      <= 32'd0;
      misalign_err <= 1'b0;
    end else if (redirect_valid && (state != HALT)) begin
      // Any delivered-but-unaccepted word and any concurrent ack belong to
      // the old path, so both are discarded.
      inst_valid <= 1'b0;
      if (is_aligned(redirect_target)) begin
        pc    <= redirect_target;
        state <= stall ? IDLE : FETCH;
      end else begin
        misalign_err <= 1'b1;
        state        <= HALT;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!stall) state <= FETCH;
        end
        FETCH: begin
          // stall is deliberately not sampled here: a launched request
          // must complete before anything else happens.
          if (imem_ack) begin
            inst_data  <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc_plus4;
            state      <= DELIVER;
          end
        end
        DELIVER: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= stall ? IDLE : FETCH;
          end
        end
        HALT: begin
          inst_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: table-driven bench for pc_fetch_ctrl. Each vector holds
// the outputs expected at the current falling edge and the inputs to drive
// for the next rising edge. Reset corner cases are hand-written afterwards.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_data;
    logic [31:0] e_ipc;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  pc_fetch_ctrl #(.RESET_PC(32'h0100_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .pc_plus4        (pc_plus4),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // stall rv tgt ack rdata ready | req addr iv data ipc err
  task automatic add(input logic s, input logic rv, input logic [31:0] tgt,
                     input logic ack, input logic [31:0] rd, input logic rdy,
                     input logic ereq, input logic [31:0] eaddr, input logic eiv,
                     input logic [31:0] edata, input logic [31:0] eipc, input logic eerr);
    vec_t v;
    v.stall = s; v.rv = rv; v.tgt = tgt; v.ack = ack; v.rdata = rd; v.ready = rdy;
    v.e_req = ereq; v.e_addr = eaddr; v.e_iv = eiv; v.e_data = edata;
    v.e_ipc = eipc; v.e_err = eerr;
    vq.push_back(v);
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rd, input logic rdy);
    stall = s; redirect_valid = rv; redirect_target = tgt;
    imem_ack = ack; imem_rdata = rd; inst_ready = rdy;
  endtask

  initial begin
    // Boot, three-instruction stream
    add(0,0,0,          0,0,            0, 0,32'h0100_0000,0,32'h0,          32'h0,          0);
    add(0,0,0,          1,32'h0050_0093,1, 1,32'h0100_0000,0,32'h0,          32'h0,          0);
    add(0,0,0,          0,0,            1, 0,32'h0100_0004,1,32'h0050_0093,32'h0100_0000,0);
    add(0,0,0,          1,32'h00A0_0113,1, 1,32'h0100_0004,0,32'h0050_0093,32'h0100_0000,0);
    add(0,0,0,          0,0,            1, 0,32'h0100_0008,1,32'h00A0_0113,32'h0100_0004,0);
    add(0,0,0,          1,32'h0020_81B3,0, 1,32'h0100_0008,0,32'h00A0_0113,32'h0100_0004,0);
    // Decode back-pressure for five cycles; stray ack ignored
    add(0,0,0,          1,32'hDEAD_BEEF,0, 0,32'h0100_000C,1,32'h0020_81B3,32'h0100_0008,0);
    add(0,0,0,          0,0,            0, 0,32'h0100_000C,1,32'h0020_81B3,32'h0100_0008,0);
    add(0,0,0,          0,0,            0, 0,32'h0100_000C,1,32'h0020_81B3,32'h0100_0008,0);
    add(0,0,0,          0,0,            0, 0,32'h0100_000C,1,32'h0020_81B3,32'h0100_0008,0);
    add(0,0,0,          0,0,            0, 0,32'h0100_000C,1,32'h0020_81B3,32'h0100_0008,0);
    add(0,0,0,          0,0,            1, 0,32'h0100_000C,1,32'h0020_81B3,32'h0100_0008,0);
    // Wait state, then redirect colliding with ack
    add(0,0,0,          0,0,            0, 1,32'h0100_000C,0,32'h0020_81B3,32'h0100_0008,0);
    add(0,1,32'h0100_0040,1,32'h1111_1111,0, 1,32'h0100_000C,0,32'h0020_81B3,32'h0100_0008,0);
    add(0,0,0,          1,32'h2222_2222,0, 1,32'h0100_0040,0,32'h0020_81B3,32'h0100_0008,0);
    // Redirect out of DELIVER to the top word of the address space
    add(0,1,32'hFFFF_FFFC,0,0,          0, 0,32'h0100_0044,1,32'h2222_2222,32'h0100_0040,0);
    add(0,0,0,          1,32'h3333_3333,0, 1,32'hFFFF_FFFC,0,32'h2222_2222,32'h0100_0040,0);
    // Wrapped PC; accept under stall -> IDLE
    add(1,0,0,          0,0,            1, 0,32'h0000_0000,1,32'h3333_3333,32'hFFFF_FFFC,0);
    add(1,0,0,          0,0,            0, 0,32'h0000_0000,0,32'h3333_3333,32'hFFFF_FFFC,0);
    add(1,0,0,          1,32'h4444_4444,0, 0,32'h0000_0000,0,32'h3333_3333,32'hFFFF_FFFC,0);
    add(0,0,0,          0,0,            0, 0,32'h0000_0000,0,32'h3333_3333,32'hFFFF_FFFC,0);
    // Misaligned redirect -> HALT, later redirect/ack ignored
    add(0,1,32'h0100_0042,0,0,          0, 1,32'h0000_0000,0,32'h3333_3333,32'hFFFF_FFFC,0);
    add(0,1,32'h0100_0040,1,32'h5555_5555,1, 0,32'h0000_0000,0,32'h3333_3333,32'hFFFF_FFFC,1);
    add(0,0,0,          1,32'h6666_6666,1, 0,32'h0000_0000,0,32'h3333_3333,32'hFFFF_FFFC,1);
    add(0,0,0,          0,0,            0, 0,32'h0000_0000,0,32'h3333_3333,32'hFFFF_FFFC,1);

    // Reset state
    drive(0,0,0,0,0,0);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst misalign_err", {31'd0, misalign_err}, 32'd0);
    chk("rst imem_addr", imem_addr, 32'h0100_0000);
    chk("rst inst_data", inst_data, 32'd0);
    chk("rst inst_pc", inst_pc, 32'd0);
    rst = 1'b0;
    #1;

    foreach (vq[i]) begin
      chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vq[i].e_req});
      chk($sformatf("v%0d imem_addr", i), imem_addr, vq[i].e_addr);
      chk($sformatf("v%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vq[i].e_iv});
      chk($sformatf("v%0d inst_data", i), inst_data, vq[i].e_data);
      chk($sformatf("v%0d inst_pc", i), inst_pc, vq[i].e_ipc);
      chk($sformatf("v%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, vq[i].e_err});
      chk($sformatf("v%0d pc_plus4", i), pc_plus4, vq[i].e_addr + 32'd4);
      drive(vq[i].stall, vq[i].rv, vq[i].tgt, vq[i].ack, vq[i].rdata, vq[i].ready);
      @(negedge clk); #1;
    end

    // Asynchronous reset out of HALT clears the sticky error immediately
    drive(1,0,0,0,0,0);
    rst = 1'b1;
    #1;
    chk("halt-rst misalign_err", {31'd0, misalign_err}, 32'd0);
    chk("halt-rst imem_addr", imem_addr, 32'h0100_0000);
    chk("halt-rst inst_pc", inst_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("stalled idle imem_req", {31'd0, imem_req}, 32'd0);

    // Redirect while stalled in IDLE: pc moves, no request yet
    drive(1,1,32'h0000_0100,0,0,0);
    @(negedge clk); #1;
    chk("idle redirect imem_req", {31'd0, imem_req}, 32'd0);
    chk("idle redirect imem_addr", imem_addr, 32'h0000_0100);
    drive(0,0,0,0,0,0);
    @(negedge clk); #1;
    chk("idle release imem_req", {31'd0, imem_req}, 32'd1);
    chk("idle release imem_addr", imem_addr, 32'h0000_0100);

    // Reset mid-fetch; an ack arriving during and after reset is ignored
    drive(1,0,0,1,32'h7777_7777,0);
    rst = 1'b1;
    #1;
    chk("midfetch rst imem_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("late ack inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("late ack inst_data", inst_data, 32'd0);
    chk("late ack imem_req", {31'd0, imem_req}, 32'd0);
    chk("late ack imem_addr", imem_addr, 32'h0100_0000);
    drive(0,0,0,0,0,0);
    @(negedge clk); #1;
    chk("restart imem_req", {31'd0, imem_req}, 32'd1);
    chk("restart imem_addr", imem_addr, 32'h0100_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
